// File: rtl/cfg_region_manager.sv
// cfg_region_manager: decodes RX FIFO command bytes into per-region colour writes; `define CFG_FRAME_SYNC_EN to hold writes for vsync.
// Latency: write valid 1 cycle after the last colour byte; notify 1 cycle after handshake / PING / mode byte.
// Backpressure: c_valid holds addr/data until c_ready; the RX FIFO is not popped while a write is pending.
module cfg_region_manager #(
  parameter int REGIONS        = 4,
  parameter int COLOR_WIDTH    = 12,
  parameter int TIMEOUT_CYCLES = 1000,
  localparam int PAYLOAD_BYTES = (COLOR_WIDTH + 7) / 8,
  localparam int ADDR_WIDTH    = (REGIONS > 1) ? $clog2(REGIONS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_empty,
  input  logic [7:0]             rx_data,
  output logic                   rx_rd,
  output logic [ADDR_WIDTH-1:0]  c_addr,
  output logic [COLOR_WIDTH-1:0] c_data,
  output logic                   c_valid,
  input  logic                   c_ready,
  input  logic                   vsync,
  output logic [2:0]             split_mode,
  output logic [1:0]             cfg_status,
  output logic [7:0]             notif_code,
  output logic                   notif_valid,
  output logic [1:0]             err_code,
  output logic                   err_valid,
  output logic [15:0]            cmd_count
);

  localparam int ASM_W = PAYLOAD_BYTES * 8;
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] OP_COLOR = 2'b00;
  localparam logic [1:0] OP_MODE  = 2'b01;
  localparam logic [1:0] OP_PING  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  localparam logic [1:0] ERR_OPCODE  = 2'b01;
  localparam logic [1:0] ERR_REGION  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  // State encoding doubles as the cfg_status value.
  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_PAYLOAD = 2'b01,
    S_ISSUE   = 2'b10,
    S_WAIT    = 2'b11
  } state_t;

  state_t            state, state_nxt;
  logic [7:0]        hdr_q;
  logic [2:0]        byte_cnt_q;
  logic [TW-1:0]     tmo_q;
  logic [ASM_W-1:0]  asm_q;
  logic [ASM_W-1:0]  asm_nxt;
  logic [1:0]        rx_op;
  logic              region_bad;
  logic              hdr_starts_payload;
  logic              last_byte;
  logic              tmo_hit;
  logic              frame_go;

  assign rx_op              = rx_data[7:6];
  assign region_bad         = {1'b0, rx_data[5:0]} >= 7'(REGIONS);
  assign hdr_starts_payload = (rx_op == OP_MODE) || (rx_op == OP_COLOR && !region_bad);
  assign last_byte          = (hdr_q[7:6] == OP_MODE) || (byte_cnt_q == 3'(PAYLOAD_BYTES - 1));
  assign tmo_hit            = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  // MSB-first assembly; bytes shifted past the top are dropped.
  assign asm_nxt            = (asm_q << 8) | ASM_W'(rx_data);

`ifdef CFG_FRAME_SYNC_EN
  logic vsync_q;

  always_ff @(posedge clk) begin
    if (rst) vsync_q <= 1'b0;
    else     vsync_q <= vsync;
  end

  assign frame_go = vsync & ~vsync_q;
`else
  logic unused_vsync;
  assign unused_vsync = vsync;
  assign frame_go     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (rx_rd && hdr_starts_payload) state_nxt = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        if (rx_rd) begin
          if (last_byte) begin
            if (hdr_q[7:6] == OP_MODE) state_nxt = S_IDLE;
`ifdef CFG_FRAME_SYNC_EN
            else                       state_nxt = S_WAIT;
`else
            else                       state_nxt = S_ISSUE;
`endif
          end
        end else if (tmo_hit) begin
          state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (c_ready) state_nxt = S_IDLE;
      end
      S_WAIT: begin
        if (frame_go) state_nxt = S_ISSUE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rx_rd      = !rx_empty && (state == S_IDLE || state == S_PAYLOAD);
    c_valid    = (state == S_ISSUE);
    cfg_status = state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_q       <= '0;
      byte_cnt_q  <= '0;
      tmo_q       <= '0;
      asm_q       <= '0;
      c_addr      <= '0;
      c_data      <= '0;
      split_mode  <= '0;
      notif_code  <= '0;
      notif_valid <= 1'b0;
      err_code    <= '0;
      err_valid   <= 1'b0;
      cmd_count   <= '0;
    end else begin
      notif_valid <= 1'b0;
      err_valid   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_rd) begin
            hdr_q      <= rx_data;
            byte_cnt_q <= '0;
            tmo_q      <= '0;
            asm_q      <= '0;
            if (rx_op == OP_RSVD) begin
              err_code  <= ERR_OPCODE;
              err_valid <= 1'b1;
            end else if (rx_op == OP_COLOR && region_bad) begin
              err_code  <= ERR_REGION;
              err_valid <= 1'b1;
            end else if (rx_op == OP_PING) begin
              notif_code  <= rx_data;
              notif_valid <= 1'b1;
              cmd_count   <= cmd_count + 16'd1;
            end
          end
        end
        S_PAYLOAD: begin
          if (rx_rd) begin
            tmo_q      <= '0;
            byte_cnt_q <= byte_cnt_q + 3'd1;
            asm_q      <= asm_nxt;
            if (hdr_q[7:6] == OP_MODE) begin
              split_mode  <= rx_data[2:0];
              notif_code  <= hdr_q;
              notif_valid <= 1'b1;
              cmd_count   <= cmd_count + 16'd1;
            end else if (last_byte) begin
              c_data <= asm_nxt[COLOR_WIDTH-1:0];
              c_addr <= hdr_q[ADDR_WIDTH-1:0];
            end
          end else if (tmo_hit) begin
            err_code  <= ERR_TIMEOUT;
            err_valid <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        S_ISSUE: begin
          if (c_ready) begin
            notif_code  <= hdr_q;
            notif_valid <= 1'b1;
            cmd_count   <= cmd_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
